imem_fetch_port: RTL and testbench



---
 rtl/imem_fetch_port.sv | 103 ++++++++++
 tb/tb_imem_fetch_port.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_port.sv
// Byte-addressed instruction store with a valid/ready request port and a registered,
// MIPS-decoded read response. Also serves as the program loader (byte-enabled writes).
module imem_fetch_port #(
    parameter int unsigned DEPTH_BYTES = 64,   // power of two, >= 4
    parameter bit          BIG_ENDIAN  = 1'b1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        InsMemRW,
    input  logic [31:0] IAddr,
    input  logic [31:0] IDataIn,
    input  logic [3:0]  ByteEn,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] inst,
    output logic [5:0]  op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  sa,
    output logic [5:0]  funct,
    output logic [15:0] immediate,
    output logic [1:0]  fault,
    output logic [31:0] fetch_count
);

    localparam int          AW        = $clog2(DEPTH_BYTES);
    localparam logic [31:0] LAST_WORD = 32'(DEPTH_BYTES - 4);

    logic [7:0]    mem_q [DEPTH_BYTES];
    logic [AW-1:0] idx;
    logic [AW-1:0] lane_addr [4];
    logic [31:0]   rd_word;
    logic [1:0]    fault_d;
    logic [31:0]   inst_d;
    logic          rd_fire;
    logic          wr_fire;

    logic          rsp_valid_q;
    logic [31:0]   inst_q;
    logic [1:0]    fault_q;
    logic [31:0]   cnt_q;

    assign idx     = IAddr[AW-1:0];
    assign fault_d = {IAddr > LAST_WORD, IAddr[1:0] != 2'b00};

    // lane j is inst[8j+7:8j]; its byte offset within the word depends on byte order
    generate
        for (genvar j = 0; j < 4; j++) begin : g_lane
            localparam logic [AW-1:0] OFF = AW'(BIG_ENDIAN ? (3 - j) : j);
            assign lane_addr[j]     = idx + OFF;
            assign rd_word[8*j +: 8] = mem_q[lane_addr[j]];
        end
    endgenerate

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign rd_fire   = req_valid && req_ready && !InsMemRW;
    assign wr_fire   = req_valid && req_ready && InsMemRW && (fault_d == 2'b00);
    assign inst_d    = (fault_d != 2'b00) ? 32'h0 : rd_word;

    // array is deliberately outside the reset domain: contents survive RST_n
    always_ff @(posedge CLK) begin
        if (wr_fire) begin
            for (int j = 0; j < 4; j++) begin
                if (ByteEn[j]) mem_q[lane_addr[j]] <= IDataIn[8*j +: 8];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            rsp_valid_q <= 1'b0;
            inst_q      <= 32'h0;
            fault_q     <= 2'b00;
            cnt_q       <= 32'h0;
        end else begin
            if (rsp_valid_q && rsp_ready) cnt_q <= cnt_q + 32'd1;
            if (rd_fire) begin
                rsp_valid_q <= 1'b1;
                inst_q      <= inst_d;
                fault_q     <= fault_d;
            end else if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign inst        = inst_q;
    assign fault       = fault_q;
    assign fetch_count = cnt_q;
    assign op          = inst_q[31:26];
    assign rs          = inst_q[25:21];
    assign rt          = inst_q[20:16];
    assign rd          = inst_q[15:11];
    assign sa          = inst_q[10:6];
    assign funct       = inst_q[5:0];
    assign immediate   = inst_q[15:0];

endmodule

// File: tb/tb_imem_fetch_port.sv
// Bench for imem_fetch_port: a big-endian and a little-endian instance share stimulus
// (each with its own write data) and are checked every cycle against a byte-array model.
module tb_imem_fetch_port;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        rw = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wd_b = '0;
    logic [31:0] wd_l = '0;
    logic [3:0]  be = '0;
    logic        rsp_ready = 1'b0;

    logic        rdy_b, vld_b, rdy_l, vld_l;
    logic [31:0] inst_b, inst_l, cnt_b, cnt_l;
    logic [5:0]  op_b, op_l, fn_b, fn_l;
    logic [4:0]  rs_b, rs_l, rt_b, rt_l, rd_b, rd_l, sa_b, sa_l;
    logic [15:0] imm_b, imm_l;
    logic [1:0]  flt_b, flt_l;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 CLK = ~CLK;

    imem_fetch_port #(.DEPTH_BYTES(64), .BIG_ENDIAN(1'b1)) dut_b (
        .CLK(CLK), .RST_n(RST_n), .req_valid(req_valid), .req_ready(rdy_b),
        .InsMemRW(rw), .IAddr(addr), .IDataIn(wd_b), .ByteEn(be),
        .rsp_valid(vld_b), .rsp_ready(rsp_ready), .inst(inst_b), .op(op_b),
        .rs(rs_b), .rt(rt_b), .rd(rd_b), .sa(sa_b), .funct(fn_b),
        .immediate(imm_b), .fault(flt_b), .fetch_count(cnt_b));

    imem_fetch_port #(.DEPTH_BYTES(64), .BIG_ENDIAN(1'b0)) dut_l (
        .CLK(CLK), .RST_n(RST_n), .req_valid(req_valid), .req_ready(rdy_l),
        .InsMemRW(rw), .IAddr(addr), .IDataIn(wd_l), .ByteEn(be),
        .rsp_valid(vld_l), .rsp_ready(rsp_ready), .inst(inst_l), .op(op_l),
        .rs(rs_l), .rt(rt_l), .rd(rd_l), .sa(sa_l), .funct(fn_l),
        .immediate(imm_l), .fault(flt_l), .fetch_count(cnt_l));

    // Reference model: one pending-response slot plus a plain byte array per instance.
    logic [7:0]  mb [64];
    logic [7:0]  ml [64];
    bit          m_valid;
    logic [31:0] m_inst_b, m_inst_l, m_cnt;
    logic [1:0]  m_fault, mf;
    int          ma;
    bit          m_take, m_acc;

    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            m_valid = 0; m_inst_b = 0; m_inst_l = 0; m_fault = 0; m_cnt = 0;
        end else begin
            m_take = m_valid && rsp_ready;
            m_acc  = req_valid && (!m_valid || rsp_ready);
            mf     = {addr > 32'd60, addr[1:0] != 2'b00};
            ma     = int'(addr[5:0]);
            if (m_take) m_cnt = m_cnt + 1;
            if (m_acc && rw) begin
                if (mf == 2'b00) begin
                    for (int k = 0; k < 4; k++) begin
                        if (be[3-k]) mb[ma+k] = wd_b[31-8*k -: 8];
                        if (be[k])   ml[ma+k] = wd_l[8*k +: 8];
                    end
                end
            end else if (m_acc) begin
                m_valid  = 1;
                m_fault  = mf;
                m_inst_b = (mf != 0) ? 32'h0 : {mb[ma], mb[ma+1], mb[ma+2], mb[ma+3]};
                m_inst_l = (mf != 0) ? 32'h0 : {ml[ma+3], ml[ma+2], ml[ma+1], ml[ma]};
            end
            if (!(m_acc && !rw) && m_take) m_valid = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_port(input string t, input logic v, input logic r, input logic [31:0] i,
                            input logic [31:0] flds, input logic [15:0] imm, input logic [1:0] f,
                            input logic [31:0] c, input logic [31:0] ei);
        chk({t, ".rsp_valid"}, 32'(v), 32'(m_valid));
        chk({t, ".req_ready"}, 32'(r), 32'(!m_valid || rsp_ready));
        chk({t, ".inst"}, i, ei);
        chk({t, ".fields"}, flds, ei);
        chk({t, ".immediate"}, 32'(imm), 32'(ei[15:0]));
        chk({t, ".fault"}, 32'(f), 32'(m_fault));
        chk({t, ".fetch_count"}, c, m_cnt);
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            cmp_port("be", vld_b, rdy_b, inst_b, {op_b, rs_b, rt_b, rd_b, sa_b, fn_b}, imm_b,
                     flt_b, cnt_b, m_inst_b);
            cmp_port("le", vld_l, rdy_l, inst_l, {op_l, rs_l, rt_l, rd_l, sa_l, fn_l}, imm_l,
                     flt_l, cnt_l, m_inst_l);
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] db, input logic [31:0] dl,
                         input logic [3:0] e, input logic rr);
        req_valid = v; rw = w; addr = a; wd_b = db; wd_l = dl; be = e; rsp_ready = rr;
    endtask

    task automatic check_mem;
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("memb[%0d]", i), 32'(dut_b.mem_q[i]), 32'(mb[i]));
            chk($sformatf("meml[%0d]", i), 32'(dut_l.mem_q[i]), 32'(ml[i]));
        end
    endtask

    logic [31:0] words_b [16];
    logic [7:0]  ref_bytes [4];

    initial begin
        ref_bytes[0] = 8'h8C; ref_bytes[1] = 8'h22; ref_bytes[2] = 8'h00; ref_bytes[3] = 8'h04;
        tick; tick;
        RST_n = 1'b1;
        cmp_en = 1'b1;
        #1;
        chk("reset.rsp_valid", 32'(vld_b), 32'd0);
        chk("reset.req_ready", 32'(rdy_b), 32'd1);
        chk("reset.inst", inst_b, 32'd0);
        chk("reset.fault", 32'(flt_b), 32'd0);
        chk("reset.fetch_count", cnt_b, 32'd0);

        // load every word; word 0 holds bytes 8C 22 00 04 in both arrays, word 2 is zero
        for (int w = 0; w < 16; w++) begin
            words_b[w] = (w == 0) ? 32'h8C220004 : (w == 2) ? 32'h0 : $urandom;
            drive(1, 1, 32'(w * 4), words_b[w],
                  (w == 0) ? 32'h0400228C : (w == 2) ? 32'h0 : $urandom, 4'hF, 1);
            tick;
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("load.memb[%0d]", k), 32'(dut_b.mem_q[k]), 32'(ref_bytes[k]));
            chk($sformatf("load.meml[%0d]", k), 32'(dut_l.mem_q[k]), 32'(ref_bytes[k]));
        end

        // back-to-back reads of 0 and 4
        drive(1, 0, 32'h0, 0, 0, 0, 1); tick;
        chk("rd0.rsp_valid", 32'(vld_b), 32'd1);
        chk("rd0.inst_be", inst_b, 32'h8C220004);
        chk("rd0.op", 32'(op_b), 32'h23);
        chk("rd0.rs", 32'(rs_b), 32'd1);
        chk("rd0.rt", 32'(rt_b), 32'd2);
        chk("rd0.immediate", 32'(imm_b), 32'h0004);
        chk("rd0.fault", 32'(flt_b), 32'd0);
        chk("rd0.inst_le", inst_l, 32'h0400228C);
        drive(1, 0, 32'h4, 0, 0, 0, 1); tick;
        chk("rd4.rsp_valid", 32'(vld_b), 32'd1);
        chk("rd4.inst_be", inst_b, words_b[1]);
        drive(0, 0, 0, 0, 0, 0, 1); tick;

        // byte-enable write then read-back on the next edge
        drive(1, 1, 32'h8, 32'hAABBCCDD, 32'hAABBCCDD, 4'b1010, 1); tick;
        drive(1, 0, 32'h8, 0, 0, 0, 1); tick;
        chk("be_wr.inst_be", inst_b, 32'hAA00CC00);
        chk("be_wr.inst_le", inst_l, 32'hAA00CC00);

        // mid-stream reset with a response pending
        drive(1, 0, 32'h0, 0, 0, 0, 0); tick;
        chk("pre_rst.rsp_valid", 32'(vld_b), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 RST_n = 1'b0;
        #1;
        chk("rst.rsp_valid_be", 32'(vld_b), 32'd0);
        chk("rst.rsp_valid_le", 32'(vld_l), 32'd0);
        chk("rst.fetch_count_be", cnt_b, 32'd0);
        chk("rst.fetch_count_le", cnt_l, 32'd0);
        tick;
        RST_n = 1'b1;
        for (int k = 0; k < 4; k++)
            chk($sformatf("rst.memb[%0d]", k), 32'(dut_b.mem_q[k]), 32'(ref_bytes[k]));

        // backpressure
        drive(1, 0, 32'h0, 0, 0, 0, 0); tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            chk("bp.req_ready", 32'(rdy_b), 32'd0);
            chk("bp.inst", inst_b, 32'h8C220004);
            chk("bp.fetch_count", cnt_b, 32'd0);
            tick;
        end
        rsp_ready = 1'b1; tick;
        chk("bp.fetch_count_after", cnt_b, 32'd1);
        chk("bp.rsp_valid_after", 32'(vld_b), 32'd0);

        // faults
        drive(1, 0, 32'h2, 0, 0, 0, 1); tick;
        chk("f_mis.fault", 32'(flt_b), 32'b01);
        chk("f_mis.inst", inst_b, 32'h0);
        drive(1, 0, 32'h40, 0, 0, 0, 1); tick;
        chk("f_rng.fault", 32'(flt_b), 32'b10);
        chk("f_rng.inst_le", inst_l, 32'h0);
        drive(1, 0, 32'h3D, 0, 0, 0, 1); tick;
        chk("f_both.fault", 32'(flt_b), 32'b11);
        drive(1, 1, 32'h40, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, 1); tick;
        drive(1, 1, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, 1); tick;
        drive(0, 0, 0, 0, 0, 0, 1); tick;
        chk("f_wr.memb[0]", 32'(dut_b.mem_q[0]), 32'h8C);
        chk("f_wr.memb[63]", 32'(dut_b.mem_q[63]), 32'(words_b[15][7:0]));
        check_mem;

        // randomized traffic
        for (int c = 0; c < 2500; c++) begin
            drive(($urandom % 4) != 0, ($urandom % 4) == 0,
                  (($urandom % 8) != 0) ? 32'($urandom_range(0, 15) * 4) : 32'($urandom_range(0, 71)),
                  $urandom, $urandom, 4'($urandom), ($urandom % 4) != 0);
            tick;
        end
        drive(0, 0, 0, 0, 0, 0, 1); tick; tick;
        check_mem;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
